vec_alu_sequencer: RTL and testbench
====================================

Name: vec_alu_sequencer

Overview:
Command-driven sequencer that walks a vector of operands through the team's shared 64-bit lane ALU. It accepts one vector command (op, element width, length, base addresses) and reads operand triples a/b/c from the vector operand banks. It issues each triple to the ALU with a one-cycle enable, captures the registered ALU result and writes it to the destination bank. It sits between the vector issue logic and the ALU/operand memories, and is the only block that drives the ALU enable.

Parameters:
AW, 8, operand/result bank address width
VLW, 8, vector-length field width (max length 2^VLW-1 elements)

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept command (IDLE only)
cmd_op  in  3  ALU operation: 0 add, 1 mul, 2 sub, 3 mul-add; 4-7 illegal
cmd_width  in  3  element width code: 0=8b, 1=16b, 2=32b, 3=64b; 4-7 illegal
cmd_vl  in  VLW  number of elements
cmd_src_base  in  AW  first operand address (same address in a/b/c banks)
cmd_dst_base  in  AW  first result address
rd_en  out  1  operand bank read strobe; data valid next cycle
rd_addr  out  AW  operand read address
rd_a, rd_b, rd_c  in  64 each  operand bank read data
alu_a, alu_b, alu_c  out  64 each  ALU operands
alu_op  out  3  ALU operation
alu_width  out  3  ALU width code
alu_enable  out  1  ALU enable, one cycle per element
alu_out  in  64  registered ALU result, valid cycle after alu_enable
wr_en  out  1  result write request
wr_addr  out  AW  result address
wr_data  out  64  result data
wr_ready  in  1  result bank accepts write when wr_en & wr_ready
busy  out  1  command in progress
done  out  1  one-cycle pulse at command completion
err  out  1  sticky illegal-command flag, cleared on next accepted command

Behaviour:
- Reset (async, rstn=0): state IDLE; all outputs 0 except cmd_ready=1; internal index, latched command and operand registers cleared. Reset mid-command abandons it: no further rd_en/alu_enable/wr_en, no done.
- States: IDLE, READ, EXEC, WB, DONE.
- IDLE: cmd_ready=1. On cmd_valid: latch op, width, vl, bases; clear err; idx=0.
  - cmd_op>3 or cmd_width>3: set err, go DONE (no memory/ALU activity).
  - cmd_vl==0: go DONE, err stays 0.
  - otherwise: go READ.
- READ (1 cycle): rd_en=1, rd_addr=src_base+idx (mod 2^AW). Next state EXEC.
- EXEC (1 cycle): capture rd_a/b/c onto alu_a/b/c, registered with the rd_en response. alu_enable=1; alu_op and alu_width equal the latched command. Next state WB.
- WB: wr_en=1, wr_addr=dst_base+idx (mod 2^AW), wr_data=alu_out (full 64 bits, no masking; ALU zero-extends narrow results). Hold all WB outputs stable while wr_ready=0.
  - On wr_ready=1 with idx==vl-1: go DONE.
  - On wr_ready=1 otherwise: idx++ and go READ.
- DONE (1 cycle): done=1, busy=0 next cycle, go IDLE; cmd_ready rises the cycle after done.
- busy=1 in READ/EXEC/WB/DONE. cmd_valid outside IDLE is ignored; cmd_ready=0 there.
- Throughput: 3 cycles per element with wr_ready=1; total for vl=N is 3N+1 cycles from acceptance to done (inclusive of done).
- alu_enable is never asserted outside EXEC. alu_a/b/c hold their last values between elements. rd_en and wr_en are never asserted in the same cycle.
- Address wrap at 2^AW is silent; no error.
- idx is VLW bits; vl=2^VLW-1 completes without overflow.

Test Plan:
- Reset then vl=4, op=0, width=0, src=0x10, dst=0x20, banks a[i]=i+0xFE, b[i]=1, wr_ready=1 -> writes 0x20..0x23 = 0xFF,0x100,0x101,0x102; done at cycle 13 after acceptance; alu_enable pulses exactly 4 times.
- op=3, width=3, vl=1, a=3, b=5, c=7 -> one write 0x16 to dst; err=0.
- vl=0, op=1 -> no rd_en, alu_enable or wr_en; done 1 cycle after acceptance; err=0.
- op=5 or width=6 -> err=1, done pulse, no bank/ALU activity; next legal command clears err.
- wr_ready low for 3 cycles on element 1 of vl=2 -> wr_en/wr_addr/wr_data held constant, no extra alu_enable, correct final writes.
- rstn low during WB of element 2 (vl=5) -> outputs return to reset values immediately, no done; a new command after release runs normally from idx 0.

Source files
------------

// File: rtl/vec_alu_sequencer.sv
// vec_alu_sequencer: walks one vector command through the shared 64-bit lane ALU.
// Each element takes three cycles: operand read, ALU issue, result write-back.
// Operand read data arrives the cycle after rd_en. It is presented to the ALU in
// that same cycle and also captured so that alu_a/b/c hold between elements.
// The ALU result is presented to the result bank directly on the first WB cycle.
// It is captured at the same time so that wr_data stays stable while wr_ready is low.
module vec_alu_sequencer #(
    parameter int AW  = 8,
    parameter int VLW = 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [2:0]     cmd_op,
    input  logic [2:0]     cmd_width,
    input  logic [VLW-1:0] cmd_vl,
    input  logic [AW-1:0]  cmd_src_base,
    input  logic [AW-1:0]  cmd_dst_base,
    output logic           rd_en,
    output logic [AW-1:0]  rd_addr,
    input  logic [63:0]    rd_a,
    input  logic [63:0]    rd_b,
    input  logic [63:0]    rd_c,
    output logic [63:0]    alu_a,
    output logic [63:0]    alu_b,
    output logic [63:0]    alu_c,
    output logic [2:0]     alu_op,
    output logic [2:0]     alu_width,
    output logic           alu_enable,
    input  logic [63:0]    alu_out,
    output logic           wr_en,
    output logic [AW-1:0]  wr_addr,
    output logic [63:0]    wr_data,
    input  logic           wr_ready,
    output logic           busy,
    output logic           done,
    output logic           err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [VLW-1:0] idx_q, idx_d;
    logic [VLW-1:0] vl_q, vl_d;
    logic [2:0]     op_q, op_d;
    logic [2:0]     width_q, width_d;
    logic [AW-1:0]  src_q, src_d;
    logic [AW-1:0]  dst_q, dst_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;
    logic           cmd_ready_q, cmd_ready_d;
    logic           done_q, done_d;
    logic           rd_en_q, rd_en_d;
    logic [AW-1:0]  rd_addr_q, rd_addr_d;
    logic           alu_enable_q, alu_enable_d;
    logic           wr_en_q, wr_en_d;
    logic [AW-1:0]  wr_addr_q, wr_addr_d;
    logic           wb_first_q, wb_first_d;
    logic [63:0]    wr_hold_q, wr_hold_d;
    logic [63:0]    opnd_a_q, opnd_a_d;
    logic [63:0]    opnd_b_q, opnd_b_d;
    logic [63:0]    opnd_c_q, opnd_c_d;

    logic           illegal_s;
    logic           last_elem_s;

    assign illegal_s   = cmd_op[2] | cmd_width[2];
    assign last_elem_s = (idx_q == (vl_q - VLW'(1)));

    // Next-state and next-output computation for the sequencer FSM.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        vl_d         = vl_q;
        op_d         = op_q;
        width_d      = width_q;
        src_d        = src_q;
        dst_d        = dst_q;
        err_d        = err_q;
        busy_d       = busy_q;
        cmd_ready_d  = cmd_ready_q;
        done_d       = 1'b0;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        alu_enable_d = 1'b0;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wb_first_d   = 1'b0;
        wr_hold_d    = wr_hold_q;
        opnd_a_d     = opnd_a_q;
        opnd_b_d     = opnd_b_q;
        opnd_c_d     = opnd_c_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    width_d     = cmd_width;
                    vl_d        = cmd_vl;
                    src_d       = cmd_src_base;
                    dst_d       = cmd_dst_base;
                    idx_d       = {VLW{1'b0}};
                    busy_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                    if (illegal_s) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (cmd_vl == {VLW{1'b0}}) begin
                        err_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d     = 1'b0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = cmd_src_base;
                        state_d   = S_READ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                alu_enable_d = 1'b1;
                state_d      = S_EXEC;
            end
            S_EXEC: begin
                // Keep the operands just issued so alu_a/b/c hold afterwards.
                opnd_a_d   = rd_a;
                opnd_b_d   = rd_b;
                opnd_c_d   = rd_c;
                wr_en_d    = 1'b1;
                wr_addr_d  = dst_q + AW'(idx_q);
                wb_first_d = 1'b1;
                state_d    = S_WB;
            end
            S_WB: begin
                if (wb_first_q) begin
                    wr_hold_d = alu_out;
                end else begin
                    wr_hold_d = wr_hold_q;
                end
                if (wr_ready) begin
                    if (last_elem_s) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d     = idx_q + VLW'(1);
                        rd_en_d   = 1'b1;
                        rd_addr_d = src_q + AW'(idx_q) + AW'(1);
                        state_d   = S_READ;
                    end
                end else begin
                    wr_en_d = 1'b1;
                    state_d = S_WB;
                end
            end
            S_DONE: begin
                busy_d      = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                busy_d      = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State, latched command and registered outputs; reset abandons any command.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            idx_q        <= {VLW{1'b0}};
            vl_q         <= {VLW{1'b0}};
            op_q         <= 3'd0;
            width_q      <= 3'd0;
            src_q        <= {AW{1'b0}};
            dst_q        <= {AW{1'b0}};
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= {AW{1'b0}};
            alu_enable_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= {AW{1'b0}};
            wb_first_q   <= 1'b0;
            wr_hold_q    <= 64'd0;
            opnd_a_q     <= 64'd0;
            opnd_b_q     <= 64'd0;
            opnd_c_q     <= 64'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            vl_q         <= vl_d;
            op_q         <= op_d;
            width_q      <= width_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            cmd_ready_q  <= cmd_ready_d;
            done_q       <= done_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            alu_enable_q <= alu_enable_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wb_first_q   <= wb_first_d;
            wr_hold_q    <= wr_hold_d;
            opnd_a_q     <= opnd_a_d;
            opnd_b_q     <= opnd_b_d;
            opnd_c_q     <= opnd_c_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign alu_enable = alu_enable_q;
    assign alu_op     = op_q;
    assign alu_width  = width_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;

    // Operand read data is live during the issue cycle, held copy otherwise.
    assign alu_a = alu_enable_q ? rd_a : opnd_a_q;
    assign alu_b = alu_enable_q ? rd_b : opnd_b_q;
    assign alu_c = alu_enable_q ? rd_c : opnd_c_q;

    // Fresh ALU result on the first write-back cycle, captured copy while stalled.
    assign wr_data = wr_en_q ? (wb_first_q ? alu_out : wr_hold_q) : 64'd0;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Directed bench for vec_alu_sequencer with behavioural operand banks and a
// full-width stand-in ALU (registered result, updated only on alu_enable).
module tb_vec_alu_sequencer;

    logic        clk;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_width;
    logic [7:0]  cmd_vl;
    logic [7:0]  cmd_src_base;
    logic [7:0]  cmd_dst_base;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [63:0] rd_a, rd_b, rd_c;
    logic [63:0] alu_a, alu_b, alu_c;
    logic [2:0]  alu_op, alu_width;
    logic        alu_enable;
    logic [63:0] alu_out;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [63:0] wr_data;
    logic        wr_ready;
    logic        busy, done, err;

    int vectors;
    int miscompares;

    logic [63:0] bank_a [256];
    logic [63:0] bank_b [256];
    logic [63:0] bank_c [256];

    int n_rd, n_alu, n_done, n_overlap;
    logic [7:0]  wq_addr [$];
    logic [63:0] wq_data [$];
    int rd0, alu0, done0;

    vec_alu_sequencer #(.AW(8), .VLW(8)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_width(cmd_width), .cmd_vl(cmd_vl),
        .cmd_src_base(cmd_src_base), .cmd_dst_base(cmd_dst_base),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .alu_op(alu_op), .alu_width(alu_width), .alu_enable(alu_enable),
        .alu_out(alu_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand banks: synchronous read, data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_a <= bank_a[rd_addr];
            rd_b <= bank_b[rd_addr];
            rd_c <= bank_c[rd_addr];
        end
    end

    // Stand-in lane ALU: registered full 64-bit result, held when not enabled.
    always @(posedge clk) begin
        if (alu_enable) begin
            case (alu_op)
                3'd0:    alu_out <= alu_a + alu_b;
                3'd1:    alu_out <= alu_a * alu_b;
                3'd2:    alu_out <= alu_a - alu_b;
                3'd3:    alu_out <= alu_a * alu_b + alu_c;
                default: alu_out <= 64'd0;
            endcase
        end
    end

    // Activity counters and accepted-write log.
    always @(posedge clk) begin
        if (rd_en) n_rd++;
        if (alu_enable) n_alu++;
        if (done) n_done++;
        if (rd_en && wr_en) n_overlap++;
        if (wr_en && wr_ready) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [2:0] w, input logic [7:0] vl,
                         input logic [7:0] src, input logic [7:0] dst);
        @(negedge clk);
        rd0 = n_rd; alu0 = n_alu; done0 = n_done;
        wq_addr.delete(); wq_data.delete();
        cmd_op = op; cmd_width = w; cmd_vl = vl;
        cmd_src_base = src; cmd_dst_base = dst;
        cmd_valid = 1'b1;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_ready_before_accept: got %b want 1", cmd_ready);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({cmd_ready, busy, done, err, rd_en, alu_enable, wr_en} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 1000000",
                     {cmd_ready, busy, done, err, rd_en, alu_enable, wr_en});
        end
        vectors++;
        if ((wr_data | alu_a | alu_b | alu_c) !== 64'd0 || wr_addr !== 8'd0 || rd_addr !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_data: wr_data=%h alu_a=%h wr_addr=%h rd_addr=%h want zeros",
                     wr_data, alu_a, wr_addr, rd_addr);
        end
        rstn = 1'b1;
    endtask

    task automatic test_basic_add();
        logic [63:0] exp_d [4];
        int cyc;
        exp_d[0] = 64'hFF; exp_d[1] = 64'h100; exp_d[2] = 64'h101; exp_d[3] = 64'h102;
        for (int i = 0; i < 4; i++) begin
            bank_a[8'h10 + i] = 64'hFE + 64'(i);
            bank_b[8'h10 + i] = 64'd1;
            bank_c[8'h10 + i] = 64'd0;
        end
        issue(3'd0, 3'd0, 8'd4, 8'h10, 8'h20);
        cyc = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin cyc = k; break; end
        end
        vectors++;
        if (cyc != 13) begin
            miscompares++;
            $display("FAIL add_done_cycle: got %0d want 13", cyc);
        end
        vectors++;
        if (n_alu - alu0 != 4 || n_rd - rd0 != 4) begin
            miscompares++;
            $display("FAIL add_pulses: alu_enable=%0d rd_en=%0d want 4/4", n_alu - alu0, n_rd - rd0);
        end
        vectors++;
        if (wq_addr.size() != 4) begin
            miscompares++;
            $display("FAIL add_write_count: got %0d want 4", wq_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (wq_addr[i] !== 8'h20 + 8'(i) || wq_data[i] !== exp_d[i]) begin
                    miscompares++;
                    $display("FAIL add_write%0d: got %h:%h want %h:%h", i, wq_addr[i], wq_data[i],
                             8'h20 + 8'(i), exp_d[i]);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL add_after_done: busy=%b ready=%b done=%b want 0 1 0", busy, cmd_ready, done);
        end
    endtask

    task automatic test_mul_add();
        int cyc;
        bank_a[8'h30] = 64'd3; bank_b[8'h30] = 64'd5; bank_c[8'h30] = 64'd7;
        issue(3'd3, 3'd3, 8'd1, 8'h30, 8'h60);
        cyc = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin cyc = k; break; end
        end
        vectors++;
        if (cyc != 4 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL madd_done: cycle=%0d err=%b want 4 0", cyc, err);
        end
        vectors++;
        if (wq_addr.size() != 1 || wq_addr[0] !== 8'h60 || wq_data[0] !== 64'h16) begin
            miscompares++;
            $display("FAIL madd_write: n=%0d got %h:%h want 60:16", wq_addr.size(), wq_addr[0], wq_data[0]);
        end
    endtask

    task automatic test_zero_len();
        int cyc;
        issue(3'd1, 3'd0, 8'd0, 8'h00, 8'h00);
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin cyc = k; break; end
        end
        vectors++;
        if (cyc != 1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len_done: cycle=%0d err=%b want 1 0", cyc, err);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (n_rd != rd0 || n_alu != alu0 || wq_addr.size() != 0) begin
            miscompares++;
            $display("FAIL zero_len_activity: rd=%0d alu=%0d wr=%0d want 0 0 0",
                     n_rd - rd0, n_alu - alu0, wq_addr.size());
        end
    endtask

    task automatic test_illegal();
        logic [2:0] ops [2];
        logic [2:0] ws [2];
        int cyc;
        ops[0] = 3'd5; ws[0] = 3'd0;
        ops[1] = 3'd0; ws[1] = 3'd6;
        for (int t = 0; t < 2; t++) begin
            issue(ops[t], ws[t], 8'd3, 8'h10, 8'hA0);
            cyc = 0;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (done === 1'b1) begin cyc = k; break; end
            end
            vectors++;
            if (cyc != 1 || err !== 1'b1) begin
                miscompares++;
                $display("FAIL illegal%0d_done: cycle=%0d err=%b want 1 1", t, cyc, err);
            end
            repeat (3) @(negedge clk);
            vectors++;
            if (err !== 1'b1 || n_rd != rd0 || n_alu != alu0 || wq_addr.size() != 0) begin
                miscompares++;
                $display("FAIL illegal%0d_sticky: err=%b rd=%0d alu=%0d wr=%0d want 1 0 0 0",
                         t, err, n_rd - rd0, n_alu - alu0, wq_addr.size());
            end
        end
        issue(3'd0, 3'd0, 8'd1, 8'h10, 8'hA0);
        @(negedge clk);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_clear: err=%b want 0", err);
        end
        for (int k = 0; k < 20 && done !== 1'b1; k++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_wr_stall();
        int cyc;
        bank_a[8'h40] = 64'd100;    bank_b[8'h40] = 64'd1;
        bank_a[8'h41] = 64'h1000;   bank_b[8'h41] = 64'h10;
        issue(3'd2, 3'd2, 8'd2, 8'h40, 8'h50);
        cyc = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k >= 6 && k <= 9) begin
                vectors++;
                if (wr_en !== 1'b1 || wr_addr !== 8'h51 || wr_data !== 64'hFF0 || rd_en !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_hold_c%0d: wr_en=%b addr=%h data=%h want 1 51 ff0", k, wr_en,
                             wr_addr, wr_data);
                end
            end
            if (k == 4) wr_ready = 1'b0;
            if (k == 9) wr_ready = 1'b1;
            if (done === 1'b1) begin cyc = k; break; end
        end
        wr_ready = 1'b1;
        vectors++;
        if (cyc != 10 || n_alu - alu0 != 2) begin
            miscompares++;
            $display("FAIL stall_done: cycle=%0d alu=%0d want 10 2", cyc, n_alu - alu0);
        end
        vectors++;
        if (wq_addr.size() != 2 || wq_addr[0] !== 8'h50 || wq_data[0] !== 64'd99 ||
            wq_addr[1] !== 8'h51 || wq_data[1] !== 64'hFF0) begin
            miscompares++;
            $display("FAIL stall_writes: n=%0d %h:%h %h:%h want 50:63 51:ff0", wq_addr.size(),
                     wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
        end
    endtask

    task automatic test_wrap();
        bank_a[8'hFF] = 64'd1;  bank_b[8'hFF] = 64'd2;
        bank_a[8'h00] = 64'd10; bank_b[8'h00] = 64'd20;
        issue(3'd0, 3'd1, 8'd2, 8'hFF, 8'hFF);
        for (int k = 0; k < 100 && done !== 1'b1; k++) @(negedge clk);
        vectors++;
        if (wq_addr.size() != 2 || wq_addr[0] !== 8'hFF || wq_data[0] !== 64'd3 ||
            wq_addr[1] !== 8'h00 || wq_data[1] !== 64'd30 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_writes: n=%0d %h:%h %h:%h err=%b want ff:3 00:1e err 0", wq_addr.size(),
                     wq_addr[0], wq_data[0], wq_addr[1], wq_data[1], err);
        end
        @(negedge clk);
    endtask

    task automatic test_max_vl();
        int cyc;
        int bad;
        for (int i = 0; i < 256; i++) begin
            bank_a[i] = 64'(i);
            bank_b[i] = 64'h100;
        end
        issue(3'd0, 3'd3, 8'd255, 8'h00, 8'h00);
        cyc = 0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin cyc = k; break; end
        end
        vectors++;
        if (cyc != 766) begin
            miscompares++;
            $display("FAIL maxvl_done_cycle: got %0d want 766", cyc);
        end
        bad = 0;
        for (int i = 0; i < wq_addr.size(); i++) begin
            if (wq_addr[i] !== 8'(i) || wq_data[i] !== 64'(i) + 64'h100) bad++;
        end
        vectors++;
        if (wq_addr.size() != 255 || bad != 0) begin
            miscompares++;
            $display("FAIL maxvl_writes: n=%0d bad=%0d want 255 0", wq_addr.size(), bad);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) begin
            bank_a[8'h70 + i] = 64'd1000 + 64'(i);
            bank_b[8'h70 + i] = 64'd1;
        end
        issue(3'd0, 3'd0, 8'd5, 8'h70, 8'h80);
        repeat (9) @(negedge clk);
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 8'h82) begin
            miscompares++;
            $display("FAIL midrst_pre: wr_en=%b addr=%h want 1 82", wr_en, wr_addr);
        end
        rstn = 1'b0;
        #1;
        vectors++;
        if ({cmd_ready, busy, done, rd_en, alu_enable, wr_en} !== 6'b100000 || wr_data !== 64'd0) begin
            miscompares++;
            $display("FAIL midrst_outputs: ctrl=%b wr_data=%h want 100000 0",
                     {cmd_ready, busy, done, rd_en, alu_enable, wr_en}, wr_data);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        rd0 = n_rd; alu0 = n_alu; done0 = n_done;
        repeat (10) @(negedge clk);
        vectors++;
        if (n_done != done0 || n_rd != rd0 || n_alu != alu0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_quiet: done=%0d rd=%0d alu=%0d busy=%b want 0 0 0 0",
                     n_done - done0, n_rd - rd0, n_alu - alu0, busy);
        end
        issue(3'd0, 3'd0, 8'd2, 8'h70, 8'h80);
        for (int k = 0; k < 100 && done !== 1'b1; k++) @(negedge clk);
        vectors++;
        if (wq_addr.size() != 2 || wq_addr[0] !== 8'h80 || wq_data[0] !== 64'd1001 ||
            wq_addr[1] !== 8'h81 || wq_data[1] !== 64'd1002) begin
            miscompares++;
            $display("FAIL midrst_rerun: n=%0d %h:%0d %h:%0d want 80:1001 81:1002", wq_addr.size(),
                     wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
        end
        @(negedge clk);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        n_rd = 0; n_alu = 0; n_done = 0; n_overlap = 0;
        rd_a = 64'd0; rd_b = 64'd0; rd_c = 64'd0; alu_out = 64'd0;
        for (int i = 0; i < 256; i++) begin
            bank_a[i] = 64'd0; bank_b[i] = 64'd0; bank_c[i] = 64'd0;
        end
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_width = 3'd0; cmd_vl = 8'd0;
        cmd_src_base = 8'd0; cmd_dst_base = 8'd0; wr_ready = 1'b1;

        test_reset();
        test_basic_add();
        test_mul_add();
        test_zero_len();
        test_illegal();
        test_wr_stall();
        test_wrap();
        test_max_vl();
        test_mid_reset();

        vectors++;
        if (n_overlap != 0) begin
            miscompares++;
            $display("FAIL rd_wr_overlap: got %0d cycles want 0", n_overlap);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
